// File: rtl/div_seq_32_if.sv
// Handshake and operand/result bundle between the EX-stage issue logic and the divider.
interface div_seq_32_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_seq_32.sv
// Iterative restoring divider (DIV/DIVU): one trial subtraction per cycle, LO=quotient, HI=remainder.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_seq_32 #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  div_seq_32_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_zero_r;

  logic             dd_neg;
  logic             dv_neg;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;

  always_comb begin
    dd_neg  = bus.is_signed & bus.dividend[WIDTH-1];
    dv_neg  = bus.is_signed & bus.divisor[WIDTH-1];
    dd_mag  = dd_neg ? -bus.dividend : bus.dividend;
    dv_mag  = dv_neg ? -bus.divisor  : bus.divisor;
    // P always stays below the divisor, so only its low WIDTH bits are stored;
    // the shifted value is the full WIDTH+1-bit partial remainder.
    shifted = {p, q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    // Top bit of the WIDTH+1-bit difference is set exactly when the subtraction borrows.
    borrow  = trial[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      div_zero_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            div_zero_r <= 1'b0;
            q_neg      <= dd_neg ^ dv_neg;
            r_neg      <= dd_neg;
            if (bus.divisor == '0) begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              div_zero_r  <= 1'b1;
              done_r      <= 1'b1;
              state       <= DONE;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (dd_mag < dv_mag) begin
              quotient_r  <= '0;
              remainder_r <= bus.dividend;
              done_r      <= 1'b1;
              state       <= DONE;
            end
`endif
            else begin
              p      <= '0;
              q      <= dd_mag;
              dvs    <= dv_mag;
              cnt    <= '0;
              busy_r <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          p   <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], ~borrow};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient_r  <= q_neg ? -q : q;
          remainder_r <= r_neg ? -p : p;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.div_zero  = div_zero_r;
endmodule

// File: tb/tb_div_seq_32.sv
// Randomized and directed checks of div_seq_32 against a 64-bit arithmetic reference model.
module tb_div_seq_32;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   done_pulses;

  div_seq_32_if #(.WIDTH(32)) bus ();

  div_seq_32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Truncating division computed in 64-bit arithmetic; signed overflow needs no special case there.
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output bit dz, output int lat);
    longint x, y, lq, lr, ax, ay;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 0;
    end else begin
      x  = s ? longint'($signed(a)) : longint'({32'd0, a});
      y  = s ? longint'($signed(b)) : longint'({32'd0, b});
      lq = x / y;
      lr = x % y;
      q  = lq[31:0];
      r  = lr[31:0];
      dz = 1'b0;
      ax = (x < 0) ? -x : x;
      ay = (y < 0) ? -y : y;
      lat = 33;
`ifdef DIV_EARLY_OUT_EN
      if (ax < ay) lat = 0;
`else
      if (ax < ay) lat = 33;
`endif
    end
  endfunction

  // Presents an operation, lets the next edge accept it, then scrambles the operand inputs.
  task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  // Called #1 after edge k+n0; n counts edges after the accepting edge k.
  task automatic expect_result(input string tag, input bit s, input logic [31:0] a,
                               input logic [31:0] b, input int n0);
    logic [31:0] eq, er;
    bit          edz;
    int          elat;
    int          n;
    ref_div(s, a, b, eq, er, edz, elat);
    n = n0;
    if (elat > 0 && n0 == 0) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(elat));
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_dz"}, 32'(bus.div_zero), 32'(edz));
  endtask

  task automatic op(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
    launch(s, a, b);
    expect_result(tag, s, a, b, 0);
  endtask

  initial begin
    int p0;
    errors        = 0;
    checks        = 0;
    done_pulses   = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_q", bus.quotient, 32'd0);
    check("rst_r", bus.remainder, 32'd0);
    check("rst_dz", 32'(bus.div_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    op("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    check("divu_big_q_const", bus.quotient, 32'h0FFF_FFFF);
    @(posedge clk); #1;

    // Second start is presented while the first result is in its DONE cycle.
    op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_q_const", bus.quotient, 32'hFFFF_FFFD);
    op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    check("div_7_m2_r_const", bus.remainder, 32'h0000_0001);
    @(posedge clk); #1;

    op("div_zero", 1'b1, 32'h1234_5678, 32'd0);
    @(posedge clk); #1;
    op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_q_const", bus.quotient, 32'h8000_0000);
    @(posedge clk); #1;

    op("divu_pre_rst", 1'b0, 32'd1000, 32'd7);
    @(posedge clk); #1;
    p0 = done_pulses;
    launch(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_q", bus.quotient, 32'd0);
    check("midrst_r", bus.remainder, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_pulses - p0), 32'd0);

    p0 = done_pulses;
    launch(1'b0, 32'd1000, 32'd10);
    for (int i = 0; i < 5; i++) begin
      bus.start     = 1'b1;
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      bus.is_signed = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    expect_result("busy_prot", 1'b0, 32'd1000, 32'd10, 5);
    @(posedge clk); #1;
    check("busy_prot_done_low", 32'(bus.done), 32'd0);
    check("busy_prot_pulses", 32'(done_pulses - p0), 32'd1);

    op("divu_3_10", 1'b0, 32'd3, 32'd10);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = $urandom;
        3: b = -32'($urandom_range(1, 300));
        default: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(51, 5000)); end
      endcase
      op("rand", s, a, b);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_seq_32.md
Name: div_seq_32

Overview:
- Iterative restoring divider for the EX stage.
- Consumes two 32-bit GPR operands and produces quotient (LO) and remainder (HI) for DIV/DIVU.
- One trial subtraction per cycle, using the same subtract-and-carry arithmetic as the EX adder/subtractor.
- Start/busy/done handshake lets the hazard unit stall the pipeline while it runs.

Parameters:
- WIDTH, 32, operand/result width; iteration count = WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- is_signed  input  1  1=DIV (signed), 0=DIVU; sampled with start
- dividend  input  WIDTH  rs operand, sampled with start
- divisor  input  WIDTH  rt operand, sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  LO result, held until next accepted start
- remainder  output  WIDTH  HI result, held until next accepted start
- div_zero  output  1  divisor was zero for the last result, held with results

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0; iteration counter=0.
  - Reset mid-operation aborts immediately with no done pulse.
  - rst has priority over start.
- States IDLE, RUN, FIX, DONE.
  - busy=1 in RUN and FIX; busy=0 in IDLE and DONE.
  - done=1 only in DONE.
- Accepting start: start=1 at edge k while in IDLE or DONE (back-to-back allowed).
  - Latches operands and is_signed; clears div_zero.
- divisor==0 at edge k:
  - Go directly to DONE.
  - quotient=all ones; remainder=dividend; div_zero=1.
  - done high in the cycle after edge k.
- divisor!=0:
  - Convert operands to magnitudes: two's-complement negate if is_signed and MSB=1.
  - Record sign flags: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend).
  - Partial remainder P (WIDTH+1 bits) = 0; Q = |dividend|; enter RUN, counter=0.
- RUN, each edge:
  - Shift {P,Q} left by 1.
  - Trial T = P - {0,|divisor|} in WIDTH+1 bits.
  - If no borrow: P=T, Q[0]=1. Else P unchanged, Q[0]=0.
  - counter++. After WIDTH iterations (edge k+WIDTH) go to FIX.
- FIX, edge k+WIDTH+1:
  - quotient = q_neg ? -Q : Q.
  - remainder = r_neg ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - Go to DONE. done is high in the cycle after edge k+WIDTH+1 (33 cycles after the start edge for WIDTH=32).
- DONE: one cycle.
  - Next edge goes to IDLE, or starts a new operation if start=1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0, div_zero=0. Falls out of the magnitude algorithm; no special case.
- Results are invariant under truncation rounding toward zero: remainder sign follows dividend, |remainder| < |divisor|.
- start while busy=1 is ignored; operands are not re-sampled.
- Operand inputs may change freely after the accepting edge.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: at start, if the divisor is nonzero and |dividend| < |divisor| in unsigned magnitude, skip RUN/FIX.
  - Go directly to DONE: quotient=0; remainder=dividend (original signed value); done the cycle after edge k.
- Undefined: full WIDTH+1 latency for every nonzero divisor.
- Results are bit-identical either way; only latency differs.

Test Plan:
- Reset mid-run:
  - Stimulus: start DIVU 100/7, assert rst at edge k+10.
  - Response: busy=0, done never pulses, quotient=0, remainder=0 after reset edge.
- Unsigned:
  - Stimulus: DIVU 0xFFFFFFFF / 0x00000010.
  - Response: done exactly 33 cycles after start edge, quotient=0x0FFFFFFF, remainder=0x0000000F, div_zero=0.
- Signed sign mix:
  - Stimulus: DIV -7/2 and 7/-2 back-to-back, second start asserted in the DONE cycle.
  - Response: first gives q=0xFFFFFFFD, r=0xFFFFFFFF; second gives q=0xFFFFFFFD, r=0x00000001; no idle gap.
- Divide by zero:
  - Stimulus: DIV 0x12345678 / 0.
  - Response: done 1 cycle after start, quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1.
- Overflow corner:
  - Stimulus: DIV 0x80000000 / 0xFFFFFFFF.
  - Response: quotient=0x80000000, remainder=0, div_zero=0.
- Busy protection:
  - Stimulus: start=1 held for 5 cycles with changing operands during RUN of DIVU 1000/10.
  - Response: result q=100, r=0; exactly one done pulse. With DIV_EARLY_OUT_EN, DIVU 3/10 gives done in 1 cycle, q=0, r=3.
